// File: rtl/cordic_nco_scheduler_if.sv
// Rotator-side bus of the NCO scheduler. The scheduler is the master. It drives the
// clock enable, phase and x/y inputs, and it receives the x/y results.
interface cordic_nco_scheduler_if #(
  parameter int unsigned PW = 24,
  parameter int unsigned IW = 16,
  parameter int unsigned OW = 16
);
  logic          cor_ce;
  logic [PW-1:0] cor_phase;
  logic [IW-1:0] cor_x;
  logic [IW-1:0] cor_y;
  logic [OW-1:0] cor_xo;
  logic [OW-1:0] cor_yo;

  modport master (
    output cor_ce, cor_phase, cor_x, cor_y,
    input  cor_xo, cor_yo
  );

  modport slave (
    input  cor_ce, cor_phase, cor_x, cor_y,
    output cor_xo, cor_yo
  );
endinterface

// File: rtl/cordic_nco_scheduler.sv
// Round-robin time-sharing of one pipelined CORDIC rotator across NCH phase accumulators.
// Define PHASE_DITHER_EN to add 4 LFSR bits of dither to the issued phase LSBs.
module cordic_nco_scheduler #(
  parameter  int unsigned NCH = 4,
  parameter  int unsigned PW  = 24,
  parameter  int unsigned IW  = 16,
  parameter  int unsigned OW  = 16,
  parameter  int unsigned LAT = 20,
  localparam int unsigned CW  = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [PW-1:0]          cfg_freq,
  input  logic [IW-1:0]          cfg_amp,
  input  logic [NCH-1:0]         ch_en,
  cordic_nco_scheduler_if.master cor,
  output logic                   out_valid,
  output logic [CW-1:0]          out_ch,
  output logic [OW-1:0]          out_x,
  output logic [OW-1:0]          out_y
);

  logic [PW-1:0]           acc_q  [NCH];
  logic [PW-1:0]           acc_d  [NCH];
  logic [PW-1:0]           freq_q [NCH];
  logic [PW-1:0]           freq_d [NCH];
  logic [IW-1:0]           amp_q  [NCH];
  logic [IW-1:0]           amp_d  [NCH];
  logic [NCH-1:0]          en_prev_q;
  logic [CW-1:0]           rr_q, rr_d;

  logic [NCH-1:0]          rise;
  logic [NCH-1:0]          elig;
  logic                    grant_v;
  logic [CW-1:0]           grant_ch;
  logic [PW-1:0]           phase_new;

  logic                    issue_v_q, issue_v_d;
  logic [CW-1:0]           issue_ch_q, issue_ch_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [IW-1:0]           xin_q, xin_d;

  logic [LAT-1:0]          tag_v_q, tag_v_d;
  logic [LAT-1:0][CW-1:0]  tag_ch_q, tag_ch_d;
  logic                    ce;

  logic                    out_valid_q, out_valid_d;
  logic [CW-1:0]           out_ch_q, out_ch_d;
  logic [OW-1:0]           out_x_q, out_x_d;
  logic [OW-1:0]           out_y_q, out_y_d;

  // A channel that has just been enabled spends one cycle having its accumulator
  // cleared. It is not eligible for a grant during that cycle.
  always_comb begin
    rise     = ch_en & ~en_prev_q;
    elig     = ch_en & en_prev_q;
    grant_v  = 1'b0;
    grant_ch = rr_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!grant_v && elig[rr_q + CW'(i)]) begin
        grant_v  = 1'b1;
        grant_ch = rr_q + CW'(i);
      end
    end
  end

`ifdef PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d    = grant_v ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                        : lfsr_q;
    phase_new = {acc_q[grant_ch][PW-1:4], acc_q[grant_ch][3:0] + lfsr_q[3:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  always_comb phase_new = acc_q[grant_ch];
`endif

  // The issue uses the pre-write freq/amp. A config write to the granted channel
  // only affects later issues.
  always_comb begin
    acc_d  = acc_q;
    freq_d = freq_q;
    amp_d  = amp_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rise[CW'(i)]) acc_d[CW'(i)] = '0;
    end
    if (grant_v) acc_d[grant_ch] = acc_q[grant_ch] + freq_q[grant_ch];
    if (cfg_we) begin
      freq_d[cfg_ch] = cfg_freq;
      amp_d[cfg_ch]  = cfg_amp;
    end
    rr_d       = grant_v ? grant_ch + CW'(1) : rr_q;
    issue_v_d  = grant_v;
    issue_ch_d = grant_v ? grant_ch : issue_ch_q;
    phase_d    = grant_v ? phase_new : phase_q;
    xin_d      = grant_v ? amp_q[grant_ch] : xin_q;
  end

  assign ce = issue_v_q | (|tag_v_q);

  // The tags advance only when the rotator advances. The tail tag therefore lines up
  // with cor_xo/cor_yo.
  always_comb begin
    tag_v_d     = tag_v_q;
    tag_ch_d    = tag_ch_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (ce) begin
      tag_v_d  = LAT'({tag_v_q, issue_v_q});
      tag_ch_d = (LAT*CW)'({tag_ch_q, issue_ch_q});
      if (tag_v_q[LAT-1]) begin
        out_valid_d = 1'b1;
        out_ch_d    = tag_ch_q[LAT-1];
        out_x_d     = cor.cor_xo;
        out_y_d     = cor.cor_yo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '{default: '0};
      freq_q      <= '{default: '0};
      amp_q       <= '{default: '0};
      en_prev_q   <= '0;
      rr_q        <= '0;
      issue_v_q   <= 1'b0;
      issue_ch_q  <= '0;
      phase_q     <= '0;
      xin_q       <= '0;
      tag_v_q     <= '0;
      tag_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      acc_q       <= acc_d;
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      en_prev_q   <= ch_en;
      rr_q        <= rr_d;
      issue_v_q   <= issue_v_d;
      issue_ch_q  <= issue_ch_d;
      phase_q     <= phase_d;
      xin_q       <= xin_d;
      tag_v_q     <= tag_v_d;
      tag_ch_q    <= tag_ch_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign cor.cor_ce    = ce;
  assign cor.cor_phase = phase_q;
  assign cor.cor_x     = xin_q;
  assign cor.cor_y     = '0;

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule
